// File: rtl/led_duel_engine.sv
// led_duel_engine: two-player LED duel with countdown, shots, lives.
// Ports: clk27/rst, start/fire1/fire2 pulses; led bar, lives, count, state, winner.
module led_duel_engine #(
  parameter int N_LED     = 16,
  parameter int LIVES     = 3,
  parameter int COUNT_LEN = 3,
  parameter int SEC_DIV   = 8,
  parameter int STEP_DIV  = 4,
  parameter int COOLDOWN  = 2
) (
  input  logic             clk27,
  input  logic             rst,
  input  logic             start,
  input  logic             fire1,
  input  logic             fire2,
  output logic [N_LED-1:0] led,
  output logic [3:0]       lives1,
  output logic [3:0]       lives2,
  output logic [3:0]       count,
  output logic [1:0]       state,
  output logic [1:0]       winner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CDOWN  = 2'd1,
    BATTLE = 2'd2,
    OVER   = 2'd3
  } st_t;

  localparam int SW  = $clog2(SEC_DIV);
  localparam int PW  = (STEP_DIV > 1) ?
                       $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] SEC_LAST =
    SW'(SEC_DIV - 1);
  localparam logic [SW-1:0] SEC_HALF =
    SW'(SEC_DIV / 2);
  localparam logic [PW-1:0] STEP_LAST =
    PW'(STEP_DIV - 1);
  localparam logic [N_LED-1:0] ONES = '1;
  localparam logic [N_LED-1:0] UPPER =
    ONES << (N_LED / 2);
  localparam logic [N_LED-1:0] LOWER =
    ONES >> (N_LED / 2);

  st_t              st_q, st_n;
  logic [N_LED-1:0] led_q, led_n;
  logic [3:0]       l1_q, l1_n;
  logic [3:0]       l2_q, l2_n;
  logic [3:0]       cnt_q, cnt_n;
  logic [1:0]       win_q, win_n;
  logic [SW-1:0]    sec_q, sec_n;
  logic [PW-1:0]    step_q, step_n;
  logic [N_LED-1:0] s1_q, s1_n;
  logic [N_LED-1:0] s2_q, s2_n;
  logic             p1_q, p1_n;
  logic             p2_q, p2_n;
  logic [3:0]       cd1_q, cd1_n;
  logic [3:0]       cd2_q, cd2_n;

  logic             go;
  logic             tick;
  logic             acc1, acc2;
  logic             hit1, hit2;
  logic [N_LED-1:0] sh1, sh2, xm, hd;

  always_ff @(posedge clk27 or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      led_q  <= ONES;
      l1_q   <= 4'(LIVES);
      l2_q   <= 4'(LIVES);
      cnt_q  <= 4'd0;
      win_q  <= 2'd0;
      sec_q  <= '0;
      step_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      p1_q   <= 1'b0;
      p2_q   <= 1'b0;
      cd1_q  <= 4'd0;
      cd2_q  <= 4'd0;
    end else begin
      st_q   <= st_n;
      led_q  <= led_n;
      l1_q   <= l1_n;
      l2_q   <= l2_n;
      cnt_q  <= cnt_n;
      win_q  <= win_n;
      sec_q  <= sec_n;
      step_q <= step_n;
      s1_q   <= s1_n;
      s2_q   <= s2_n;
      p1_q   <= p1_n;
      p2_q   <= p2_n;
      cd1_q  <= cd1_n;
      cd2_q  <= cd2_n;
    end
  end

  always_comb begin
    st_n   = st_q;
    led_n  = led_q;
    l1_n   = l1_q;
    l2_n   = l2_q;
    cnt_n  = cnt_q;
    win_n  = win_q;
    sec_n  = sec_q;
    step_n = step_q;
    s1_n   = s1_q;
    s2_n   = s2_q;
    p1_n   = p1_q;
    p2_n   = p2_q;
    cd1_n  = cd1_q;
    cd2_n  = cd2_q;
    go     = 1'b0;
    tick   = 1'b0;
    acc1   = 1'b0;
    acc2   = 1'b0;
    hit1   = 1'b0;
    hit2   = 1'b0;
    sh1    = '0;
    sh2    = '0;
    xm     = '0;
    hd     = '0;

    unique case (st_q)
      IDLE: go = start;
      CDOWN: begin
        if (sec_q == SEC_LAST) begin
          sec_n = '0;
          if (cnt_q == 4'd1) begin
            st_n   = BATTLE;
            cnt_n  = 4'd0;
            step_n = '0;
          end else begin
            cnt_n = cnt_q - 4'd1;
          end
        end else begin
          sec_n = sec_q + SW'(1);
        end
      end
      BATTLE: begin
        tick   = (step_q == STEP_LAST);
        step_n = tick ? '0 : step_q + PW'(1);
        acc1   = fire1 && (cd1_q == 4'd0);
        acc2   = fire2 && (cd2_q == 4'd0);
        if (tick) begin
          hit2 = s1_q[0];
          hit1 = s2_q[N_LED-1];
          sh1  = s1_q >> 1;
          sh2  = s2_q << 1;
          hd   = sh1 & sh2;
          // shots that swap neighbours this step
          xm   = sh1 & s2_q;
          s1_n = sh1 & ~hd & ~xm;
          s2_n = sh2 & ~hd & ~(xm << 1);
          if (p1_q) begin
            s1_n[N_LED-1] = 1'b1;
            p1_n  = 1'b0;
            cd1_n = 4'(COOLDOWN);
          end else if (cd1_q != 4'd0) begin
            cd1_n = cd1_q - 4'd1;
          end
          if (p2_q) begin
            s2_n[0] = 1'b1;
            p2_n  = 1'b0;
            cd2_n = 4'(COOLDOWN);
          end else if (cd2_q != 4'd0) begin
            cd2_n = cd2_q - 4'd1;
          end
          if (hit1 && l1_q != 4'd0)
            l1_n = l1_q - 4'd1;
          if (hit2 && l2_q != 4'd0)
            l2_n = l2_q - 4'd1;
          if (l1_n == 4'd0 || l2_n == 4'd0) begin
            st_n  = OVER;
            win_n = {l1_n == 4'd0,
                     l2_n == 4'd0};
          end
        end
        // a pulse landing on the injecting
        // tick merges with that injection
        if (acc1 && !(tick && p1_q))
          p1_n = 1'b1;
        if (acc2 && !(tick && p2_q))
          p2_n = 1'b1;
      end
      OVER: go = start;
    endcase

    if (go) begin
      st_n   = CDOWN;
      cnt_n  = 4'(COUNT_LEN);
      sec_n  = '0;
      step_n = '0;
      l1_n   = 4'(LIVES);
      l2_n   = 4'(LIVES);
      win_n  = 2'd0;
      s1_n   = '0;
      s2_n   = '0;
      p1_n   = 1'b0;
      p2_n   = 1'b0;
      cd1_n  = 4'd0;
      cd2_n  = 4'd0;
    end

    unique case (st_n)
      IDLE:   led_n = ONES;
      CDOWN:  led_n = (sec_n < SEC_HALF) ?
                      ONES : '0;
      BATTLE: led_n = s1_n | s2_n;
      OVER: begin
        unique case (win_n)
          2'd1:    led_n = UPPER;
          2'd2:    led_n = LOWER;
          2'd3:    led_n = ONES;
          default: led_n = '0;
        endcase
      end
    endcase
  end

  assign led    = led_q;
  assign lives1 = l1_q;
  assign lives2 = l2_q;
  assign count  = cnt_q;
  assign state  = st_q;
  assign winner = win_q;

endmodule

// File: tb/tb_led_duel_engine.sv
// tb_led_duel_engine: scoreboard bench for led_duel_engine.
// Stimulus queues per-cycle expectations; a monitor pops and compares.
module tb_led_duel_engine;

  logic       clk27;
  logic       rst;
  logic       start;
  logic       fire1;
  logic       fire2;
  logic [7:0] led;
  logic [3:0] lives1;
  logic [3:0] lives2;
  logic [3:0] count;
  logic [1:0] state;
  logic [1:0] winner;

  led_duel_engine #(
    .N_LED    (8),
    .LIVES    (2),
    .COUNT_LEN(3),
    .SEC_DIV  (4),
    .STEP_DIV (2),
    .COOLDOWN (1)
  ) dut (
    .clk27 (clk27),
    .rst   (rst),
    .start (start),
    .fire1 (fire1),
    .fire2 (fire2),
    .led   (led),
    .lives1(lives1),
    .lives2(lives2),
    .count (count),
    .state (state),
    .winner(winner)
  );

  typedef struct {
    int         cyc;
    bit         at_rst;
    logic [7:0] led;
    logic [3:0] l1;
    logic [3:0] l2;
    logic [3:0] cnt;
    logic [1:0] st;
    logic [1:0] win;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  initial begin
    clk27 = 1'b0;
    forever #5 clk27 = ~clk27;
  end

  always @(posedge clk27) cyc <= cyc + 1;

  task automatic push(
    input int         c,
    input logic [7:0] l,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] n,
    input logic [1:0] s,
    input logic [1:0] w,
    input bit         r,
    input string      t
  );
    exp_t e;
    e.cyc    = c;
    e.at_rst = r;
    e.led    = l;
    e.l1     = a;
    e.l2     = b;
    e.cnt    = n;
    e.st     = s;
    e.win    = w;
    e.tag    = t;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk27);
  endtask

  // countdown 3,2,1 with led blinking, then battle
  task automatic push_countdown(input int c0);
    logic [7:0] l;
    for (int j = 1; j <= 12; j++) begin
      l = (((j - 1) % 4) < 2) ? 8'hFF : 8'h00;
      push(c0 + j, l, 4'd2, 4'd2,
           4'(3 - (j - 1) / 4), 2'd1, 2'd0,
           1'b0, "countdown");
    end
    push(c0 + 13, 8'h00, 4'd2, 4'd2, 4'd0,
         2'd2, 2'd0, 1'b0, "battle_entry");
  endtask

  task automatic push_shot(
    input int c, input logic [3:0] l2v,
    input string t
  );
    logic [7:0] v;
    for (int m = 0; m < 8; m++) begin
      v = 8'h80 >> m;
      for (int h = 0; h < 2; h++)
        push(c + 2 * m + h, v, 4'd2, l2v,
             4'd0, 2'd2, 2'd0, 1'b0, t);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    bit   go_on;
    forever begin
      @(negedge clk27 or posedge rst);
      #1;
      go_on = 1'b1;
      while (go_on && sb.size() > 0) begin
        e = sb[0];
        if (e.at_rst ? !rst : (e.cyc > cyc)) begin
          go_on = 1'b0;
        end else begin
          void'(sb.pop_front());
          n_tests++;
          if (!e.at_rst && e.cyc < cyc) begin
            n_fail++;
            $display("FAIL %s cyc=%0d missed (now %0d)",
                     e.tag, e.cyc, cyc);
          end else if (led !== e.led ||
                       lives1 !== e.l1 ||
                       lives2 !== e.l2 ||
                       count !== e.cnt ||
                       state !== e.st ||
                       winner !== e.win) begin
            n_fail++;
            $display({"FAIL %s cyc=%0d got led=%h ",
                      "l=%0d/%0d cnt=%0d st=%0d ",
                      "win=%0d want led=%h l=%0d/%0d ",
                      "cnt=%0d st=%0d win=%0d"},
                     e.tag, cyc, led, lives1, lives2,
                     count, state, winner, e.led,
                     e.l1, e.l2, e.cnt, e.st, e.win);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    int c0, b, c1, b2, k;
    logic [7:0] pats [4];
    pats[0] = 8'h81;
    pats[1] = 8'h42;
    pats[2] = 8'h24;
    pats[3] = 8'h18;
    rst   = 1'b1;
    start = 1'b0;
    fire1 = 1'b0;
    fire2 = 1'b0;

    wait_cyc(2);
    #2 rst = 1'b0;
    push(3, 8'hFF, 4'd2, 4'd2, 4'd0, 2'd0,
         2'd0, 1'b0, "reset");
    push(4, 8'hFF, 4'd2, 4'd2, 4'd0, 2'd0,
         2'd0, 1'b0, "idle");

    // first game
    wait_cyc(4);
    c0 = cyc;
    start = 1'b1;
    push_countdown(c0);
    wait_cyc(c0 + 1);
    start = 1'b0;

    // single shot from player 1
    b = c0 + 13;
    wait_cyc(b);
    fire1 = 1'b1;
    push(b + 1, 8'h00, 4'd2, 4'd2, 4'd0,
         2'd2, 2'd0, 1'b0, "pre_tick");
    push_shot(b + 2, 4'd2, "shot1");
    push(b + 18, 8'h00, 4'd2, 4'd1, 4'd0,
         2'd2, 2'd0, 1'b0, "hit_p2");
    wait_cyc(b + 1);
    fire1 = 1'b0;

    // head-on pair cancels by crossing
    wait_cyc(b + 18);
    fire1 = 1'b1;
    fire2 = 1'b1;
    push(b + 19, 8'h00, 4'd2, 4'd1, 4'd0,
         2'd2, 2'd0, 1'b0, "pair_pend");
    for (int i = 0; i < 4; i++)
      for (int h = 0; h < 2; h++)
        push(b + 20 + 2 * i + h, pats[i], 4'd2,
             4'd1, 4'd0, 2'd2, 2'd0, 1'b0, "pair");
    push(b + 28, 8'h00, 4'd2, 4'd1, 4'd0,
         2'd2, 2'd0, 1'b0, "cancel");
    wait_cyc(b + 19);
    fire1 = 1'b0;
    fire2 = 1'b0;

    // second hit; pulse during cooldown dropped
    wait_cyc(b + 28);
    fire1 = 1'b1;
    push(b + 29, 8'h00, 4'd2, 4'd1, 4'd0,
         2'd2, 2'd0, 1'b0, "pend2");
    push_shot(b + 30, 4'd1, "shot2");
    push(b + 46, 8'hF0, 4'd2, 4'd0, 4'd0,
         2'd3, 2'd1, 1'b0, "over_p1");
    push(b + 47, 8'hF0, 4'd2, 4'd0, 4'd0,
         2'd3, 2'd1, 1'b0, "over_fire");
    push(b + 48, 8'hF0, 4'd2, 4'd0, 4'd0,
         2'd3, 2'd1, 1'b0, "over_hold");
    wait_cyc(b + 29);
    fire1 = 1'b0;
    wait_cyc(b + 30);
    fire1 = 1'b1;
    wait_cyc(b + 31);
    fire1 = 1'b0;

    // fire ignored in OVER
    wait_cyc(b + 46);
    fire1 = 1'b1;
    wait_cyc(b + 47);
    fire1 = 1'b0;
    fire2 = 1'b1;

    // restart from OVER
    wait_cyc(b + 48);
    fire2 = 1'b0;
    c1 = cyc;
    start = 1'b1;
    push_countdown(c1);
    wait_cyc(c1 + 1);
    start = 1'b0;

    // reset with shots in flight
    b2 = c1 + 13;
    wait_cyc(b2);
    fire1 = 1'b1;
    fire2 = 1'b1;
    push(b2 + 1, 8'h00, 4'd2, 4'd2, 4'd0,
         2'd2, 2'd0, 1'b0, "g2_pend");
    push(b2 + 2, 8'h81, 4'd2, 4'd2, 4'd0,
         2'd2, 2'd0, 1'b0, "g2_inj");
    push(b2 + 3, 8'h81, 4'd2, 4'd2, 4'd0,
         2'd2, 2'd0, 1'b0, "g2_inj");
    push(b2 + 4, 8'h42, 4'd2, 4'd2, 4'd0,
         2'd2, 2'd0, 1'b0, "g2_step");
    wait_cyc(b2 + 1);
    fire1 = 1'b0;
    fire2 = 1'b0;
    wait_cyc(b2 + 4);
    #2;
    push(0, 8'hFF, 4'd2, 4'd2, 4'd0, 2'd0,
         2'd0, 1'b1, "async_rst");
    for (int j = 5; j <= 12; j++)
      push(b2 + j, 8'hFF, 4'd2, 4'd2, 4'd0,
           2'd0, 2'd0, 1'b0, "post_rst");
    rst = 1'b1;
    wait_cyc(b2 + 6);
    #2 rst = 1'b0;
    wait_cyc(b2 + 8);
    fire1 = 1'b1;
    wait_cyc(b2 + 9);
    fire1 = 1'b0;

    k = 0;
    while (sb.size() > 0 && k < 200) begin
      @(negedge clk27);
      k++;
    end
    #2;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain left=%0d want 0",
               sb.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_duel_engine.md
# led_duel_engine

Parametrised two-player LED duel engine: players fire shots that travel along an N_LED-wide LED bar toward the opponent, and each shot that exits the far end costs that opponent one life. It runs a start / countdown / battle / game-over sequence with configurable field width, lives, countdown length, shot speed and fire cooldown. Shots meeting head-on cancel each other. It sits between the debounced/one-pulsed player inputs (keyboard or buttons) and the LED bar and seven-segment drivers.

## Interface

- N_LED, 16, LED field width (even, ≥4)
- LIVES, 3, starting lives per player (1..15)
- COUNT_LEN, 3, countdown start digit (1..9)
- SEC_DIV, 8, clk27 cycles per countdown digit (even, ≥2)
- STEP_DIV, 4, clk27 cycles per shot step (≥1)
- COOLDOWN, 2, steps a player must wait after an injection (0..15)

- clk27  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high
- start  in  1  single-cycle pulse; starts or restarts a game
- fire1  in  1  single-cycle pulse; player 1 fire (injects at LED bit N_LED-1)
- fire2  in  1  single-cycle pulse; player 2 fire (injects at LED bit 0)
- led  out  N_LED  LED bar
- lives1  out  4  player 1 lives
- lives2  out  4  player 2 lives
- count  out  4  countdown digit; 0 outside COUNTDOWN
- state  out  2  0 IDLE, 1 COUNTDOWN, 2 BATTLE, 3 OVER
- winner  out  2  0 none, 1 P1, 2 P2, 3 draw

## Operation

- All outputs are registered. Reset values: state=IDLE, led all ones, lives1=lives2=LIVES, count=0, winner=0. All shot, pending and cooldown registers are cleared.
- IDLE: led all ones. start → COUNTDOWN.
- COUNTDOWN: on entry, count=COUNT_LEN, sec_cnt=0, lives restored to LIVES, winner=0, shots/pending/cooldowns cleared.
  - led is all ones while sec_cnt < SEC_DIV/2 and all zeros otherwise.
  - When sec_cnt reaches SEC_DIV-1, count decrements. If count was 1, go to BATTLE with count=0.
  - start is ignored.
- BATTLE: shot vectors s1 (moves toward bit 0) and s2 (moves toward bit N_LED-1). led = s1 | s2. step_cnt counts 0..STEP_DIV-1; a tick occurs when step_cnt=STEP_DIV-1.
  - A fireX pulse sets pendingX only if cooldownX=0. It is dropped otherwise. A repeated pulse while pending merges with the existing one.
  - On each tick, in order:
    - Shift: s1n=s1>>1, s2n=s2<<1. A 1 leaving s1[0] is a hit on P2; a 1 leaving s2[N_LED-1] is a hit on P1.
    - Cancel: clear bits where s1n&s2n. For crossings (s1[i+1]&s2[i] before the shift), clear s1n[i] and s2n[i+1].
    - Inject: if pending1, set s1n[N_LED-1], clear pending1, set cooldown1=COOLDOWN; else, if cooldown1>0, decrement it. The same applies to P2 at s2n[0].
    - Lives: decrement by one per hit, saturating at 0. Simultaneous hits decrement both.
  - If any life reaches 0 after a tick, go to OVER. winner=1 if only lives2=0, 2 if only lives1=0, 3 if both are 0.
- OVER: led shows the winner.
  - winner 1: upper half ones.
  - winner 2: lower half ones.
  - winner 3: all ones.
  - fire is ignored; start → COUNTDOWN.
- fire pulses outside BATTLE are ignored.

## Timing

- start high at cycle t → state=1 and count=COUNT_LEN from t+1.
- state=2 from t+1+COUNT_LEN·SEC_DIV. step_cnt=0 on BATTLE entry; the first tick is STEP_DIV cycles after entry.
- A fire accepted before tick k appears in led at the bit-N_LED-1 (or bit-0) position immediately after tick k.
- That shot reaches the far end after tick k+N_LED-1. It exits, and lives update, at tick k+N_LED.
- Injections by one player are spaced at least COOLDOWN+1 ticks apart.
- rst in any state returns all registers to reset values asynchronously. No partial game state survives.

## Test plan

All scenarios use N_LED=8, LIVES=2, COUNT_LEN=3, SEC_DIV=4, STEP_DIV=2, COOLDOWN=1.

- Reset → state=0, led=0xFF, lives1=lives2=2, count=0, winner=0.
- start pulse → count reads 3, 2, 1 for 4 cycles each. led alternates 0xFF/0x00 every 2 cycles. state=2 and count=0 exactly 12 cycles after entry.
- Single fire1 → led 0x80 after the next tick, then shifts right once per tick to 0x01. On the next tick led=0x00 and lives2=1.
- fire1 and fire2 in the same cycle → led 0x81, 0x42, 0x24, 0x18, then 0x00 (crossing cancel). Lives are unchanged.
- fire1 pulse on the cycle after an injection → dropped. A second hit gives lives2=0, state=3, winner=1, led=0xF0. start → COUNTDOWN with lives restored to 2 and winner=0.
- Assert rst mid-BATTLE with shots in flight → immediate state=0, led=0xFF, lives 2/2, no shot reappears after release.
